id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 DATA_WIDTH, 32, datapath width of all data fields.
REQ-002 REG_ADDR_WIDTH, 5, register index width.
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 StallE  input  1  hold all E-side outputs this edge.
REQ-006 FlushE  input  1  load a bubble into E this edge.
REQ-007 ValidD  input  1  decode slot holds a real instruction.
REQ-008 RD1D, RD2D, ImmExtD, PCD, PCPlus4D  input  DATA_WIDTH  operands, immediate, PC, PC+4 from decode.
REQ-009 Rs1D, Rs2D, RdD  input  REG_ADDR_WIDTH  source and destination register indices.
REQ-010 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1  decoded control bits.
REQ-011 ResultSrcD  input  2  writeback result select.
REQ-012 ALUControlD  input  3  ALU operation code (000 add, 001 sub, 010 and, 011 or, 100 xor, 110 sll, 111 srl).
REQ-013 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  DATA_WIDTH  registered copies to execute stage.
REQ-014 Rs1E, Rs2E, RdE  output  REG_ADDR_WIDTH  registered indices for ALU and forwarding.
REQ-015 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE  output  as D-side  registered control.
REQ-016 ValidE  output  1  execute slot holds a real instruction.
REQ-017 BubbleCount  output  32  saturating count of bubbles entered into E.

Function
REQ-018 All state SHALL update only on rising clk while rst_n=1; no combinational path from any input to any output.
REQ-019 Per-edge priority SHALL be FlushE > StallE > load.
REQ-020 Load (FlushE=0, StallE=0, ValidD=1): every E output SHALL equal its D input one edge later (latency 1); ValidE<=1.
REQ-021 Stall (FlushE=0, StallE=1): every E output including ValidE SHALL hold; BubbleCount SHALL hold.
REQ-022 Bubble = FlushE=1, or load with ValidD=0: ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE <= 0; ResultSrcE <= 00; ALUControlE <= 000; Rs1E, Rs2E, RdE <= 0; all DATA_WIDTH fields <= 0.
REQ-023 FlushE=1 with StallE=1 SHALL produce a bubble (flush wins).
REQ-024 BubbleCount SHALL increment by 1 on every edge that loads a bubble and never otherwise.
REQ-025 BubbleCount at 32'hFFFFFFFF SHALL stay at 32'hFFFFFFFF (saturate, no wrap).
REQ-026 Invariant: RegWriteE, MemWriteE, JumpE, BranchE SHALL never be 1 while ValidE=0.
REQ-027 Invariant: RdE, Rs1E, Rs2E SHALL be 0 while ValidE=0, so forwarding never matches a bubble.
REQ-028 D-side values during a stall SHALL be ignored; the held instruction is the one loaded before the stall began.

Reset
REQ-029 rst_n=0 SHALL force every output to 0 immediately, independent of clk, including ValidE and BubbleCount.
REQ-030 While rst_n=0 all inputs SHALL be ignored; the first capture SHALL occur on the first rising edge with rst_n=1.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction; post-reset state is identical to power-up reset.

Verification
REQ-032 Reset, then load RD1D=0x11, ALUControlD=001, RdD=5, RegWriteD=1, ValidD=1 -> after one edge RD1E=0x11, ALUControlE=001, RdE=5, RegWriteE=1, ValidE=1.
REQ-033 Load instr A, then StallE=1 for 3 edges while D-side presents B -> E outputs stay A for all 3 edges; BubbleCount unchanged; B appears one edge after StallE=0.
REQ-034 FlushE=1 with StallE=1 while MemWriteD=1, RdD=7 -> next edge MemWriteE=0, RdE=0, ValidE=0, BubbleCount +1.
REQ-035 ValidD=0 with RegWriteD=1, JumpD=1 -> next edge RegWriteE=0, JumpE=0, ValidE=0, BubbleCount +1.
REQ-036 Force BubbleCount to 32'hFFFFFFFE, flush on 3 consecutive edges -> 32'hFFFFFFFF then stays 32'hFFFFFFFF.
REQ-037 Drop rst_n mid-cycle between edges with ValidE=1 -> all outputs 0 before the next clk edge; first load after release captures D-side normally.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: carries a decoded instruction into execute, with
// stall (hold), flush (bubble) and a saturating count of inserted bubbles.
module id_ex_register #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      StallE,
   input  logic                      FlushE,
   input  logic                      ValidD,
   input  logic [DATA_WIDTH-1:0]     RD1D,
   input  logic [DATA_WIDTH-1:0]     RD2D,
   input  logic [DATA_WIDTH-1:0]     ImmExtD,
   input  logic [DATA_WIDTH-1:0]     PCD,
   input  logic [DATA_WIDTH-1:0]     PCPlus4D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] RdD,
   input  logic                      RegWriteD,
   input  logic                      MemWriteD,
   input  logic                      JumpD,
   input  logic                      BranchD,
   input  logic                      ALUSrcD,
   input  logic [1:0]                ResultSrcD,
   input  logic [2:0]                ALUControlD,
   output logic [DATA_WIDTH-1:0]     RD1E,
   output logic [DATA_WIDTH-1:0]     RD2E,
   output logic [DATA_WIDTH-1:0]     ImmExtE,
   output logic [DATA_WIDTH-1:0]     PCE,
   output logic [DATA_WIDTH-1:0]     PCPlus4E,
   output logic [REG_ADDR_WIDTH-1:0] Rs1E,
   output logic [REG_ADDR_WIDTH-1:0] Rs2E,
   output logic [REG_ADDR_WIDTH-1:0] RdE,
   output logic                      RegWriteE,
   output logic                      MemWriteE,
   output logic                      JumpE,
   output logic                      BranchE,
   output logic                      ALUSrcE,
   output logic [1:0]                ResultSrcE,
   output logic [2:0]                ALUControlE,
   output logic                      ValidE,
   output logic [31:0]               BubbleCount
);

   logic        bubble;
   logic        load;
   logic [31:0] bubble_count;

   // Flush beats stall; an unstalled edge with no valid decode slot is also a bubble.
   assign bubble = FlushE | (~StallE & ~ValidD);
   assign load   = ~FlushE & ~StallE & ValidD;

   assign BubbleCount = bubble_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         ValidE      <= 1'b0;
      end else if (bubble) begin
         // Register indices are cleared too so forwarding never matches a bubble.
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         ValidE      <= 1'b0;
      end else if (load) begin
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         ImmExtE     <= ImmExtD;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= RdD;
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         ValidE      <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_count <= '0;
      end else if (bubble && (bubble_count != 32'hFFFF_FFFF)) begin
         bubble_count <= bubble_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: randomized and directed stimulus, expected E-side
// snapshots queued by the driver and compared by an independent monitor.
module tb_id_ex_register;

   typedef struct packed {
      logic        valid;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        regw;
      logic        memw;
      logic        jump;
      logic        branch;
      logic        alusrc;
      logic [1:0]  rsrc;
      logic [2:0]  aluc;
   } instr_t;

   typedef struct packed {
      instr_t      e;
      logic [31:0] bcount;
   } obs_t;

   localparam int OW = $bits(obs_t);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic StallE = 1'b0;
   logic FlushE = 1'b0;
   instr_t d_in = '0;

   logic        ValidD;
   logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]  ResultSrcD;
   logic [2:0]  ALUControlD;

   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic        ValidE;
   logic [31:0] BubbleCount;

   obs_t cur;

   assign {ValidD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD} = d_in;

   assign cur = {ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
                 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                 BubbleCount};

   id_ex_register dut (
      .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
      .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
      .ValidE(ValidE), .BubbleCount(BubbleCount)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [OW-1:0] exp_q[$];

   // reference model: the instruction currently sitting in E and the bubble tally
   instr_t      m_e = '0;
   logic [31:0] m_cnt = '0;

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d act=%h exp=%h", name, cyc, act, exp);
      end
   endtask

   // monitor: one snapshot is presented per cycle; sample on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (exp_q.size() > 0) check("e_outputs", cur, exp_q.pop_front());
         if (!ValidE) begin
            checks++;
            if ({RegWriteE, MemWriteE, JumpE, BranchE} != 4'b0 || {RdE, Rs1E, Rs2E} != 15'b0) begin
               errors++;
               $display("FAIL bubble_invariant cycle %0d ctl=%b idx=%h/%h/%h", cyc,
                        {RegWriteE, MemWriteE, JumpE, BranchE}, RdE, Rs1E, Rs2E);
            end
         end
      end
   end

   function automatic instr_t rand_instr(input logic valid);
      instr_t r;
      r.valid  = valid;
      r.rd1    = $urandom;
      r.rd2    = $urandom;
      r.imm    = $urandom;
      r.pc     = $urandom;
      r.pcp4   = $urandom;
      r.rs1    = 5'($urandom_range(0, 31));
      r.rs2    = 5'($urandom_range(0, 31));
      r.rd     = 5'($urandom_range(0, 31));
      r.regw   = 1'($urandom_range(0, 1));
      r.memw   = 1'($urandom_range(0, 1));
      r.jump   = 1'($urandom_range(0, 1));
      r.branch = 1'($urandom_range(0, 1));
      r.alusrc = 1'($urandom_range(0, 1));
      r.rsrc   = 2'($urandom_range(0, 3));
      r.aluc   = 3'($urandom_range(0, 7));
      return r;
   endfunction

   // driver: called one time unit after a falling edge; returns at the same phase
   task automatic drive(input logic f, input logic s, input instr_t d);
      FlushE = f;
      StallE = s;
      d_in   = d;
      if (f || (!s && !d.valid)) begin
         m_e = '0;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (!s) begin
         m_e = d;
      end
      exp_q.push_back({m_e, m_cnt});
      @(negedge clk);
      #1;
   endtask

   // asserts reset between edges, checks the immediate clear and that a clock
   // edge under reset captures nothing, then releases away from the edge
   task automatic do_reset(input string tag);
      #1;
      rst_n = 1'b0;
      #1;
      check({tag, "_async_clear"}, cur, '0);
      FlushE = 1'($urandom_range(0, 1));
      StallE = 1'($urandom_range(0, 1));
      d_in   = rand_instr(1'b1);
      @(posedge clk);
      #1;
      check({tag, "_held_in_reset"}, cur, '0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      m_e   = '0;
      m_cnt = '0;
      exp_q.delete();
   endtask

   instr_t a, b, t;

   initial begin
      #2;
      check("power_up_reset", cur, '0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      // single load of a known instruction
      t = '0;
      t.valid = 1'b1; t.rd1 = 32'h11; t.aluc = 3'b001; t.rd = 5'd5; t.regw = 1'b1;
      drive(1'b0, 1'b0, t);
      checks++;
      if (!(RD1E == 32'h11 && ALUControlE == 3'b001 && RdE == 5'd5 && RegWriteE && ValidE)) begin
         errors++;
         $display("FAIL first_load rd1=%h aluc=%b rd=%0d regw=%b valid=%b", RD1E, ALUControlE,
                  RdE, RegWriteE, ValidE);
      end

      // load A, stall 3 edges with B on D side, then release
      a = rand_instr(1'b1);
      b = rand_instr(1'b1);
      drive(1'b0, 1'b0, a);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, b);
      drive(1'b0, 1'b0, b);

      // flush together with stall
      t = rand_instr(1'b1);
      t.memw = 1'b1; t.rd = 5'd7;
      drive(1'b1, 1'b1, t);
      checks++;
      if (MemWriteE || RdE != 0 || ValidE || BubbleCount != 32'd1) begin
         errors++;
         $display("FAIL flush_over_stall memw=%b rd=%0d valid=%b bc=%0d exp_bc=1",
                  MemWriteE, RdE, ValidE, BubbleCount);
      end

      // invalid decode slot with live control bits
      t = rand_instr(1'b0);
      t.regw = 1'b1; t.jump = 1'b1;
      drive(1'b0, 1'b0, t);

      // reset mid-stall discards the held instruction
      drive(1'b0, 1'b0, rand_instr(1'b1));
      drive(1'b0, 1'b1, rand_instr(1'b1));
      do_reset("mid_stall");
      a = rand_instr(1'b1);
      drive(1'b0, 1'b0, a);

      // saturation of the bubble counter
      #1;
      dut.bubble_count = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom_range(0, 1)), rand_instr(1'b1));
      checks++;
      if (BubbleCount != 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL saturate bc=%h exp=ffffffff", BubbleCount);
      end
      drive(1'b0, 1'b0, rand_instr(1'b1));
      drive(1'b0, 1'b1, rand_instr(1'b0));

      // reset with a valid instruction in E, then normal capture
      do_reset("valid_e");
      drive(1'b0, 1'b0, rand_instr(1'b1));

      // random mix
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
               rand_instr(1'($urandom_range(0, 3) != 0)));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
